// File: rtl/pulse_transmitter_job_scheduler.sv
// rtl/pulse_transmitter_job_scheduler.sv - job FIFO and register-bus sequencer for the pulse transmitter
// Optional watchdog on WAIT_RUN/WAIT_END is built when PULSE_SCHED_WATCHDOG_EN is defined.
module pulse_transmitter_job_scheduler #(
    parameter int QUEUE_DEPTH = 4,
    parameter int GAP_W       = 8,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             abort,
    input  logic                             job_valid,
    output logic                             job_ready,
    input  logic [28:0]                      job_data,
    input  logic [GAP_W-1:0]                 gap_cycles,
    output logic [5:0]                       tx_address,
    output logic [31:0]                      tx_data,
    output logic [1:0]                       tx_write_n,
    input  logic [4:0]                       tx_status,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_level,
    output logic                             busy,
    output logic                             job_done,
    output logic                             job_error
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int LW = $clog2(QUEUE_DEPTH+1);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_START, S_WAIT_RUN, S_WAIT_END, S_CLEAR, S_GAP, S_STOP
    } state_t;

    state_t            state;
    logic [28:0]       mem [QUEUE_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [LW-1:0]     count_next;
    logic [GAP_W-1:0]  gap_cnt;
    logic [28:0]       head;
    logic              push;
    logic              pop;
    logic              wdog_fire;
    logic              unused_status;

    assign head          = mem[rd_ptr];
    assign push          = job_valid && job_ready;
    assign pop           = (state == S_IDLE) && enable && (queue_level != '0);
    assign count_next    = queue_level + LW'(push) - LW'(pop);
    assign unused_status = ^{tx_status[3], tx_status[1:0]};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= job_data;
        end
    end

`ifdef PULSE_SCHED_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES+1);
    logic [WW-1:0] wdog_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (state == S_START) begin
            wdog_cnt <= '0;
        end else if (state == S_WAIT_RUN || state == S_WAIT_END) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    // Fires on the cycle the count reaches the limit, so STOP follows exactly WDOG_CYCLES wait cycles.
    assign wdog_fire = (wdog_cnt == WW'(WDOG_CYCLES-1));
`else
    logic [31:0] unused_wdog;
    assign unused_wdog = WDOG_CYCLES;
    assign wdog_fire   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_level <= '0;
            job_ready   <= 1'b1;
            gap_cnt     <= '0;
            tx_address  <= '0;
            tx_data     <= '0;
            tx_write_n  <= 2'b11;
            busy        <= 1'b0;
            job_done    <= 1'b0;
            job_error   <= 1'b0;
        end else begin
            tx_write_n  <= 2'b11;
            job_done    <= 1'b0;
            job_error   <= 1'b0;
            queue_level <= count_next;
            job_ready   <= (count_next != LW'(QUEUE_DEPTH));
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            // Abort and watchdog share the STOP path; abort wins over any normal transition.
            if ((abort || wdog_fire) &&
                (state == S_CFG || state == S_START ||
                 state == S_WAIT_RUN || state == S_WAIT_END) &&
                (abort || state == S_WAIT_RUN || state == S_WAIT_END)) begin
                state      <= S_STOP;
                tx_address <= 6'h00;
                tx_data    <= 32'h20;
                tx_write_n <= 2'b00;
                job_error  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (pop) begin
                        state      <= S_CFG;
                        busy       <= 1'b1;
                        tx_address <= 6'h04;
                        tx_data    <= {1'b0, head[28:22], head[21:14], 1'b0,
                                       head[13:7], 1'b0, head[6:0]};
                        tx_write_n <= 2'b10;
                    end
                    S_CFG: begin
                        state      <= S_START;
                        tx_address <= 6'h00;
                        tx_data    <= 32'h14;
                        tx_write_n <= 2'b00;
                    end
                    S_START:    state <= S_WAIT_RUN;
                    S_WAIT_RUN: if (tx_status[4]) state <= S_WAIT_END;
                    S_WAIT_END: if (!tx_status[4]) begin
                        state      <= S_CLEAR;
                        tx_address <= 6'h00;
                        tx_data    <= 32'h04;
                        tx_write_n <= 2'b00;
                        job_done   <= 1'b1;
                        job_error  <= !tx_status[2];
                    end
                    // IDLE itself is the last idle cycle, so GAP holds gap_cycles-1 cycles.
                    S_CLEAR: if (gap_cycles > GAP_W'(1)) begin
                        state   <= S_GAP;
                        gap_cnt <= gap_cycles - GAP_W'(2);
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    S_GAP: if (gap_cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                    S_STOP: begin
                        state      <= S_CLEAR;
                        tx_address <= 6'h00;
                        tx_data    <= 32'h04;
                        tx_write_n <= 2'b00;
                        job_done   <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
